// File: rtl/mem_scan_pkg.sv
// Shared types for the BIOS/instruction ROM scan engine.
package mem_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN
  } scan_state_e;

  localparam int SCAN_ADDR_W_DEF = 12;
  localparam int CUR_EXTRA_BITS  = 1;

  // The cursor carries one extra bit so a full-range sweep cannot wrap.
  function automatic int cursor_w(input int addr_w);
    return addr_w + CUR_EXTRA_BITS;
  endfunction

endpackage

// File: rtl/valid_delay.sv
// Per-port read-valid shift register matching the memory read latency.
module valid_delay #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             inner_o
);

  logic [DEPTH:1][WIDTH-1:0] vld_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else if (flush_i) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= d_i;
      for (int i = 2; i <= DEPTH; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign q_o = vld_pipe[DEPTH];

  // Bits still travelling that will not exit on the coming edge.
  always_comb begin
    inner_o = 1'b0;
    for (int i = 1; i < DEPTH; i++) inner_o = inner_o | (|vld_pipe[i]);
  end

endmodule

// File: rtl/bios_mem_scanner.sv
// Sweeps an inclusive address range over NUM_PORTS ROM read ports, summing and counting words.
module bios_mem_scanner
  import mem_scan_pkg::*;
#(
  parameter int ADDR_WIDTH   = SCAN_ADDR_W_DEF,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_PORTS    = 2,
  parameter int READ_LATENCY = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start_i,
  input  logic                            abort_i,
  input  logic [ADDR_WIDTH-1:0]           start_addr_i,
  input  logic [ADDR_WIDTH-1:0]           end_addr_i,
  input  logic [DATA_WIDTH-1:0]           expected_i,
  output logic [NUM_PORTS-1:0]            mem_en_o,
  output logic [NUM_PORTS*ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] mem_dout_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic [DATA_WIDTH-1:0]           checksum_o,
  output logic [ADDR_WIDTH:0]             words_o,
  output logic                            match_o
);

  localparam int            CW   = cursor_w(ADDR_WIDTH);
  localparam logic [CW-1:0] STEP = CW'(NUM_PORTS);

  scan_state_e                          state_q, state_d;
  logic [CW-1:0]                        cur_q, cur_d, end_q, end_d;
  logic [CW-1:0]                        cnt_q, cnt_d, words_q, words_d;
  logic [DATA_WIDTH-1:0]                exp_q, exp_d, sum_q, sum_d, cks_q, cks_d;
  logic [NUM_PORTS-1:0]                 en_q, en_d;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                                 busy_q, busy_d, done_q, done_d, match_q, match_d;
  logic                                 flush, inflight;
  logic [NUM_PORTS-1:0]                 vld;
  logic [CW-1:0]                        base, lim;
  logic [NUM_PORTS-1:0][CW-1:0]         lane;
  logic [NUM_PORTS-1:0]                 iss_en;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] iss_addr;
  logic [DATA_WIDTH-1:0]                acc, fin_sum;
  logic [CW-1:0]                        nacc;

  valid_delay #(.WIDTH(NUM_PORTS), .DEPTH(READ_LATENCY)) u_vld (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .d_i     (en_q),
    .q_o     (vld),
    .inner_o (inflight)
  );

  // Next issue group: the start address when launching, else cursor + NUM_PORTS.
  always_comb begin
    base = (state_q == ST_IDLE) ? {1'b0, start_addr_i} : cur_q + STEP;
    lim  = (state_q == ST_IDLE) ? {1'b0, end_addr_i}   : end_q;
    for (int k = 0; k < NUM_PORTS; k++) begin
      lane[k]     = base + CW'(k);
      iss_en[k]   = (lane[k] <= lim);
      iss_addr[k] = lane[k][ADDR_WIDTH-1:0];
    end
  end

  always_comb begin
    acc  = '0;
    nacc = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (vld[k]) begin
        acc  = acc + mem_dout_i[k*DATA_WIDTH +: DATA_WIDTH];
        nacc = nacc + CW'(1);
      end
    end
    fin_sum = sum_q + acc;
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    end_d   = end_q;
    exp_d   = exp_q;
    en_d    = en_q;
    addr_d  = addr_q;
    sum_d   = fin_sum;
    cnt_d   = cnt_q + nacc;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cks_d   = cks_q;
    words_d = words_q;
    match_d = match_q;
    flush   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_ISSUE;
          cur_d   = base;
          end_d   = lim;
          exp_d   = expected_i;
          en_d    = iss_en;
          addr_d  = iss_addr;
          sum_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (abort_i) begin
          state_d = ST_IDLE;
          en_d    = '0;
          busy_d  = 1'b0;
          flush   = 1'b1;
        end else if (!iss_en[0]) begin
          state_d = ST_DRAIN;
          en_d    = '0;
        end else begin
          cur_d  = base;
          en_d   = iss_en;
          addr_d = iss_addr;
        end
      end
      ST_DRAIN: begin
        if (abort_i) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          flush   = 1'b1;
        end else if (!inflight) begin
          // The last valid bits are exiting now, so fold them straight into the results.
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cks_d   = fin_sum;
          words_d = cnt_q + nacc;
          match_d = (fin_sum == exp_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      end_q   <= '0;
      exp_q   <= '0;
      en_q    <= '0;
      addr_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cks_q   <= '0;
      words_q <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      end_q   <= end_d;
      exp_q   <= exp_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cks_q   <= cks_d;
      words_q <= words_d;
      match_q <= match_d;
    end
  end

  assign mem_en_o   = en_q;
  assign mem_addr_o = addr_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign checksum_o = cks_q;
  assign words_o    = words_q;
  assign match_o    = match_q;

endmodule

// File: tb/tb_bios_mem_scanner.sv
// Scoreboard bench: two scanner configurations against a word[a]=a ROM model.
module tb_bios_mem_scanner;

  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int NPA = 2;
  localparam int RLA = 1;
  localparam int NPB = 4;
  localparam int RLB = 3;

  typedef struct {
    logic [DW-1:0] cks;
    logic [AW:0]   words;
    logic          match;
    int            t0;
    int            lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
  logic [AW-1:0] s_addr = '0, e_addr = '0;
  logic [DW-1:0] expv = '0;

  logic [NPA-1:0] en_a;     logic [NPA*AW-1:0] addr_a; logic [NPA*DW-1:0] dout_a;
  logic [NPB-1:0] en_b;     logic [NPB*AW-1:0] addr_b; logic [NPB*DW-1:0] dout_b;
  logic busy_a, done_a, match_a, busy_b, done_b, match_b;
  logic [DW-1:0] cks_a, cks_b;
  logic [AW:0] words_a, words_b;

  int cyc = 0;
  int nvec = 0;
  int nbad = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bios_mem_scanner #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(NPA), .READ_LATENCY(RLA)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a), .abort_i(abort_a),
    .start_addr_i(s_addr), .end_addr_i(e_addr), .expected_i(expv),
    .mem_en_o(en_a), .mem_addr_o(addr_a), .mem_dout_i(dout_a),
    .busy_o(busy_a), .done_o(done_a), .checksum_o(cks_a), .words_o(words_a), .match_o(match_a));

  bios_mem_scanner #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(NPB), .READ_LATENCY(RLB)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .abort_i(abort_b),
    .start_addr_i(s_addr), .end_addr_i(e_addr), .expected_i(expv),
    .mem_en_o(en_b), .mem_addr_o(addr_b), .mem_dout_i(dout_b),
    .busy_o(busy_b), .done_o(done_b), .checksum_o(cks_b), .words_o(words_b), .match_o(match_b));

  // ROM models: word[a] = a; disabled ports return junk so unqualified adds show up.
  logic [RLA-1:0][NPA*DW-1:0] mpa;
  logic [RLB-1:0][NPB*DW-1:0] mpb;
  always @(posedge clk) begin
    for (int k = 0; k < NPA; k++)
      mpa[0][k*DW +: DW] <= en_a[k] ? {{(DW-AW){1'b0}}, addr_a[k*AW +: AW]} : 32'hDEAD_BEEF;
    for (int i = 1; i < RLA; i++) mpa[i] <= mpa[i-1];
    for (int k = 0; k < NPB; k++)
      mpb[0][k*DW +: DW] <= en_b[k] ? {{(DW-AW){1'b0}}, addr_b[k*AW +: AW]} : 32'hDEAD_BEEF;
    for (int i = 1; i < RLB; i++) mpb[i] <= mpb[i-1];
  end
  assign dout_a = mpa[RLA-1];
  assign dout_b = mpb[RLB-1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    nvec++;
    if (act !== want) begin
      nbad++;
      $display("FAIL %s: got %0d want %0d", nm, act, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done_a) begin
      if (qa.size() == 0) chk("A unexpected done", 1, 0);
      else begin
        e = qa.pop_front();
        chk("A checksum", cks_a, e.cks);
        chk("A words", words_a, e.words);
        chk("A match", match_a, e.match);
        chk("A latency", cyc - e.t0, e.lat);
        chk("A busy at done", busy_a, 0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done_b) begin
      if (qb.size() == 0) chk("B unexpected done", 1, 0);
      else begin
        e = qb.pop_front();
        chk("B checksum", cks_b, e.cks);
        chk("B words", words_b, e.words);
        chk("B match", match_b, e.match);
        chk("B latency", cyc - e.t0, e.lat);
      end
    end
  end

  // Called at a negedge; start is sampled on the following posedge.
  task automatic launch_a(input int s, input int e, input int x, input bit push,
                          input int cks, input int wds, input bit m, input int lat);
    exp_t ex;
    s_addr = AW'(s); e_addr = AW'(e); expv = DW'(x); start_a = 1'b1;
    if (push) begin
      ex.cks = DW'(cks); ex.words = (AW+1)'(wds); ex.match = m; ex.t0 = cyc + 1; ex.lat = lat;
      qa.push_back(ex);
    end
  endtask

  task automatic wait_done_a(input int maxc, output logic [NPA-1:0] last_en, output int en_cyc);
    bit got = 0;
    last_en = '0; en_cyc = 0;
    for (int i = 0; i < maxc && !got; i++) begin
      @(negedge clk);
      start_a = 1'b0; abort_a = 1'b0;
      if (done_a) got = 1;
      else if (en_a != '0) begin last_en = en_a; en_cyc++; end
    end
    if (!got) chk("A done timeout", 0, 1);
  endtask

  initial begin
    logic [NPA-1:0] last_en;
    int en_cyc;
    exp_t ex;
    bit got;

    repeat (3) @(negedge clk);
    chk("reset mem_en", en_a, 0);
    chk("reset mem_addr", addr_a, 0);
    chk("reset busy", busy_a, 0);
    chk("reset done", done_a, 0);
    chk("reset checksum", cks_a, 0);
    chk("reset words", words_a, 0);
    chk("reset match", match_a, 0);
    chk("reset B busy", busy_b, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 0..7: C=4, done at +5
    launch_a(0, 7, 28, 1, 28, 8, 1, 5);
    @(negedge clk); start_a = 1'b0;
    chk("busy after start", busy_a, 1);
    wait_done_a(20, last_en, en_cyc);

    // accepted in the done cycle; uneven tail 3..7
    launch_a(3, 7, 0, 1, 25, 5, 0, 4);
    wait_done_a(20, last_en, en_cyc);
    chk("tail last mem_en", last_en, 2'b01);
    chk("tail issue cycles", en_cyc, 3);

    // empty range
    launch_a(10, 5, 0, 1, 0, 0, 1, 2);
    wait_done_a(20, last_en, en_cyc);
    chk("empty mem_en cycles", en_cyc, 0);

    // start while busy is ignored, as are input changes
    launch_a(0, 7, 5, 1, 28, 8, 0, 5);
    @(negedge clk); start_a = 1'b0;
    start_a = 1'b1; s_addr = 100; e_addr = 200; expv = 28;
    wait_done_a(20, last_en, en_cyc);

    // abort three cycles into 0..99
    launch_a(0, 99, 4950, 0, 0, 0, 0, 0);
    @(negedge clk); start_a = 1'b0;
    @(negedge clk);
    @(negedge clk); abort_a = 1'b1;
    @(negedge clk); abort_a = 1'b0;
    chk("abort busy", busy_a, 0);
    chk("abort mem_en", en_a, 0);
    chk("abort keeps checksum", cks_a, 28);
    chk("abort keeps words", words_a, 8);
    chk("abort keeps match", match_a, 0);
    repeat (8) @(negedge clk);

    // restart with abort also high: start wins
    launch_a(0, 99, 4950, 1, 4950, 100, 1, 51);
    abort_a = 1'b1;
    wait_done_a(80, last_en, en_cyc);

    // asynchronous reset mid-scan
    @(negedge clk);
    launch_a(0, 99, 0, 0, 0, 0, 0, 0);
    repeat (5) @(negedge clk);
    start_a = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async rst busy", busy_a, 0);
    chk("async rst mem_en", en_a, 0);
    chk("async rst mem_addr", addr_a, 0);
    chk("async rst checksum", cks_a, 0);
    chk("async rst words", words_a, 0);
    chk("async rst match", match_a, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // full range on the 4-port, latency-3 instance
    s_addr = 0; e_addr = 12'hFFF; expv = 8386560; start_b = 1'b1;
    ex.cks = 8386560; ex.words = 13'd4096; ex.match = 1'b1; ex.t0 = cyc + 1; ex.lat = 1027;
    qb.push_back(ex);
    got = 0;
    for (int i = 0; i < 1200 && !got; i++) begin
      @(negedge clk); start_b = 1'b0;
      if (done_b) got = 1;
    end
    if (!got) chk("B done timeout", 0, 1);
    @(negedge clk);
    chk("B idle mem_en", en_b, 0);
    chk("A queue drained", qa.size(), 0);
    chk("B queue drained", qb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
